// File: rtl/pal_sync_decoder.sv
`timescale 1ns/1ps
// PAL sync separator and colour-burst demodulator: classifies sync-tip runs,
// tracks line/field timing and measures burst phase/amplitude per line.
module pal_sync_decoder #(
    parameter int SYNC_THRESHOLD = 4,
    parameter int BLANK_LEVEL    = 8,
    parameter int BURST_START    = 80,
    parameter int BURST_LENGTH   = 128,
    parameter int BURST_MIN      = 4096
) (
    input  logic               phaseClock,
    input  logic               reset,
    input  logic [4:0]         sample,
    output logic               hsyncPulse,
    output logic               vsyncPulse,
    output logic [9:0]         lineCount,
    output logic               locked,
    output logic               burstValid,
    output logic signed [20:0] burstI,
    output logic signed [20:0] burstQ,
    output logic               linePhase,
    output logic               colorKill
);

    localparam int          BURST_END     = BURST_START + BURST_LENGTH - 1;
    localparam logic [12:0] SPACE_MIN_POS = 13'd4507;
    localparam logic [12:0] SPACE_MAX_POS = 13'd4571;
    localparam logic [13:0] TIMEOUT_LIMIT = 14'd9080;

    typedef enum logic [1:0] {
        PC_NONE,
        PC_EQUALIZE,
        PC_HSYNC,
        PC_BROAD
    } pulse_class_t;

    function automatic logic signed [7:0] cosLut(input logic [3:0] p);
        case (p)
            4'd0:    return  8'sd127;
            4'd1:    return  8'sd117;
            4'd2:    return  8'sd90;
            4'd3:    return  8'sd49;
            4'd4:    return  8'sd0;
            4'd5:    return -8'sd49;
            4'd6:    return -8'sd90;
            4'd7:    return -8'sd117;
            4'd8:    return -8'sd127;
            4'd9:    return -8'sd117;
            4'd10:   return -8'sd90;
            4'd11:   return -8'sd49;
            4'd12:   return  8'sd0;
            4'd13:   return  8'sd49;
            4'd14:   return  8'sd90;
            default: return  8'sd117;
        endcase
    endfunction

    logic [11:0]        runCount;
    pulse_class_t       pulseClass;
    pulse_class_t       classNext;
    logic               prevBroad;
    logic [3:0]         phase;
    logic [12:0]        linePos;
    logic               lineSeen;
    logic [2:0]         consec;
    logic [13:0]        timeout;

    logic               s1Valid, s1First, s1Last;
    logic signed [5:0]  s1D;
    logic signed [7:0]  s1Cos, s1Sin;
    logic               s2Valid, s2First, s2Last;
    logic signed [13:0] s2I, s2Q;
    logic signed [20:0] accI, accQ;

    logic               inWindow;
    logic               spacingOk;
    logic signed [5:0]  dNext;
    logic signed [20:0] sumI, sumQ;
    logic [20:0]        absI, absQ;
    logic [21:0]        burstMag;

    always_comb begin
        classNext = PC_NONE;
        if (runCount >= 12'd1000)
            classNext = PC_BROAD;
        else if (runCount >= 12'd500)
            classNext = PC_NONE;
        else if (runCount >= 12'd250)
            classNext = PC_HSYNC;
        else if (runCount >= 12'd100)
            classNext = PC_EQUALIZE;
    end

    always_comb begin
        inWindow  = lineSeen && (linePos >= 13'(BURST_START)) && (linePos <= 13'(BURST_END));
        spacingOk = (linePos >= SPACE_MIN_POS) && (linePos <= SPACE_MAX_POS);
        dNext     = 6'({1'b0, sample}) - 6'(BLANK_LEVEL);
        sumI      = (s2First ? 21'sd0 : accI) + {{7{s2I[13]}}, s2I};
        sumQ      = (s2First ? 21'sd0 : accQ) + {{7{s2Q[13]}}, s2Q};
        absI      = sumI[20] ? -sumI : sumI;
        absQ      = sumQ[20] ? -sumQ : sumQ;
        burstMag  = {1'b0, absI} + {1'b0, absQ};
    end

    always_ff @(posedge phaseClock) begin
        if (reset) begin
            runCount   <= '0;
            pulseClass <= PC_NONE;
            prevBroad  <= 1'b0;
            phase      <= '0;
            linePos    <= '0;
            lineSeen   <= 1'b0;
            consec     <= '0;
            timeout    <= '0;
            s1Valid    <= 1'b0;
            s1First    <= 1'b0;
            s1Last     <= 1'b0;
            s1D        <= '0;
            s1Cos      <= '0;
            s1Sin      <= '0;
            s2Valid    <= 1'b0;
            s2First    <= 1'b0;
            s2Last     <= 1'b0;
            s2I        <= '0;
            s2Q        <= '0;
            accI       <= '0;
            accQ       <= '0;
            hsyncPulse <= 1'b0;
            vsyncPulse <= 1'b0;
            lineCount  <= '0;
            locked     <= 1'b0;
            burstValid <= 1'b0;
            burstI     <= '0;
            burstQ     <= '0;
            linePhase  <= 1'b0;
            colorKill  <= 1'b1;
        end else begin
            phase <= phase + 4'd1;

            if (sample < 5'(SYNC_THRESHOLD)) begin
                if (runCount != '1)
                    runCount <= runCount + 12'd1;
                pulseClass <= PC_NONE;
            end else begin
                runCount   <= '0;
                pulseClass <= classNext;
            end

            hsyncPulse <= (pulseClass == PC_HSYNC);
            vsyncPulse <= (pulseClass == PC_BROAD) && !prevBroad;
            if (pulseClass != PC_NONE)
                prevBroad <= (pulseClass == PC_BROAD);

            if ((pulseClass == PC_BROAD) && !prevBroad)
                lineCount <= '0;
            else if ((pulseClass == PC_HSYNC) && (lineCount != '1))
                lineCount <= lineCount + 10'd1;

            // An hsync inside the window restarts linePos, so the last-sample
            // flag never arrives and the burst outputs simply hold.
            if (pulseClass == PC_HSYNC) begin
                linePos  <= '0;
                lineSeen <= 1'b1;
            end else if (linePos != '1) begin
                linePos <= linePos + 13'd1;
            end

            s1Valid <= inWindow;
            s1First <= inWindow && (linePos == 13'(BURST_START));
            s1Last  <= inWindow && (linePos == 13'(BURST_END));
            s1D     <= dNext;
            s1Cos   <= cosLut(phase);
            s1Sin   <= cosLut(phase + 4'd12);

            s2Valid <= s1Valid;
            s2First <= s1First;
            s2Last  <= s1Last;
            s2I     <= 14'(s1D) * 14'(s1Cos);
            s2Q     <= 14'(s1D) * 14'(s1Sin);

            if (s2Valid) begin
                accI <= sumI;
                accQ <= sumQ;
            end
            burstValid <= s2Valid && s2Last;
            if (s2Valid && s2Last) begin
                burstI    <= sumI;
                burstQ    <= sumQ;
                linePhase <= !sumQ[20];
                colorKill <= (burstMag < 22'(BURST_MIN));
            end

            // Timeout loss overrides any burst result landing in the same cycle.
            if (pulseClass != PC_NONE) begin
                timeout <= '0;
                if (pulseClass == PC_HSYNC) begin
                    if (spacingOk) begin
                        if (consec >= 3'd3)
                            locked <= 1'b1;
                        if (consec != 3'd4)
                            consec <= consec + 3'd1;
                    end else begin
                        consec <= '0;
                    end
                end
            end else if (timeout == TIMEOUT_LIMIT) begin
                locked    <= 1'b0;
                consec    <= '0;
                colorKill <= 1'b1;
            end else begin
                timeout <= timeout + 14'd1;
            end
        end
    end

endmodule
